seq_1010_pattern_tx: RTL
========================

Name: seq_1010_pattern_tx

Overview:
Serial pattern transmitter: the stimulus-side counterpart of the 1010 Moore sequence detectors. On a start request it captures a PAT_W-bit pattern and a repeat count. It then shifts the pattern out MSB-first on a single-bit line, one bit per clock, with a valid qualifier. Used to drive detector blocks (overlapping and non-overlapping) in self-checking benches and on-chip loopback.

Parameters:
- PAT_W, 4, pattern width in bits (2..16).
- CNT_W, 4, repeat-count width.
- GAP_CYC, 0, idle cycles inserted between repetitions (0..15).
- OVL_LEN, 2, prefix bits shared between consecutive repetitions when SEQ_TX_OVERLAP_EN is defined (0..PAT_W-1).

Ports:
- Clk, input, 1, system clock; all logic on the rising edge.
- Rst, input, 1, asynchronous active-low reset.
- Start, input, 1, transmit request; sampled only in IDLE.
- Abort, input, 1, synchronous cancel of the transfer in progress.
- Pattern, input, PAT_W, pattern to send; captured on accepted Start.
- Reps, input, CNT_W, number of repetitions; 0 is treated as 1; captured on accepted Start.
- Out, output, 1, serial data bit.
- Out_Vld, output, 1, Out carries a pattern bit this cycle.
- Busy, output, 1, high whenever CS != IDLE.
- Done, output, 1, one-cycle completion pulse.
- CS, output, 3, current state (debug).
- NS, output, 3, next state (debug).

Behaviour:
- Reset (Rst=0, asynchronous):
  - CS=IDLE; Out=0, Out_Vld=0, Done=0, Busy=0.
  - Pattern register, bit index and repeat counter cleared.
  - Reset mid-transfer aborts immediately; no Done pulse.
- State encoding: IDLE=000, SHIFT=001, GAP=010, DONE=011; other codes recover to IDLE on the next edge.
- All outputs are registered (Moore style): Out, Out_Vld and Done depend only on state and registers.
- IDLE:
  - Start=1 at edge k: capture Pattern and Reps (Reps=0 becomes 1), set bit index to PAT_W-1, go to SHIFT.
  - Start=0: stay in IDLE.
- SHIFT:
  - Out = captured pattern bit at the current index; Out_Vld=1.
  - First bit appears in cycle k+1, so latency from Start to the first bit is 1 cycle.
  - The index decrements at each edge.
  - After bit 0:
    - If repetitions remain and GAP_CYC>0: go to GAP.
    - If repetitions remain and GAP_CYC=0: reload the index and stay in SHIFT (back-to-back, no bubble).
    - If this was the last repetition: go to DONE.
- GAP: Out=0, Out_Vld=0 for exactly GAP_CYC cycles, then SHIFT with the index reloaded.
- DONE: Done=1, Out_Vld=0 for exactly one cycle, then IDLE.
  - Start is accepted in the cycle after DONE, not during DONE.
- Start while Busy: ignored; the captured Pattern and Reps are unaffected by input changes during a transfer.
- Abort=1 in any non-IDLE state:
  - Next edge goes to IDLE; Out=0, Out_Vld=0, no Done.
  - Abort takes priority over every other transition.
  - Abort in IDLE has no effect; Start and Abort together in IDLE means Abort wins and nothing starts.
- Counter widths: repeat counter CNT_W bits; the maximum Reps=2^CNT_W-1 must complete without wrap.
- Total Out_Vld cycles without overlap = PAT_W*Reps.

Optional Feature:
Macro SEQ_TX_OVERLAP_EN.
- Defined:
  - Repetition 1 sends all PAT_W bits.
  - Each later repetition sends only the low PAT_W-OVL_LEN bits (index reloads to PAT_W-OVL_LEN-1). This models overlapping occurrences; for 1010 with OVL_LEN=2 and Reps=3 the stream is 1010 10 10.
  - Total Out_Vld cycles = PAT_W + (Reps-1)*(PAT_W-OVL_LEN).
  - GAP_CYC still applies between segments.
- Undefined: every repetition sends the full pattern; OVL_LEN is unused.

Test Plan:
1. Basic single transfer. Release reset; Pattern=1010, Reps=1, GAP_CYC=0; Start pulsed at edge k.
   - Out/Out_Vld = 1/1, 0/1, 1/1, 0/1 in cycles k+1..k+4.
   - Done=1 in k+5; Busy high k+1..k+5; IDLE at k+6.
2. Back-to-back repetitions. Pattern=1010, Reps=3, no macro.
   - 12 consecutive valid bits 101010101010, then one Done.
   - An overlapping 1010 detector fed this stream pulses 5 times; a non-overlapping detector pulses 3 times.
3. Overlap build. Build with SEQ_TX_OVERLAP_EN, Pattern=1010, Reps=3.
   - Valid stream is 10101010 (8 bits), then Done.
   - Build with GAP_CYC=2: stream 1010, 2 cycles Out_Vld=0, 10, 2 cycles, 10.
4. Reps=0 and ignored Start. Reps=0 produces exactly one repetition. Start re-asserted during SHIFT with a different Pattern changes nothing in the stream.
5. Abort mid-stream. Abort=1 while the third bit is on Out.
   - Next cycle: CS=IDLE, Out_Vld=0, no Done.
   - A new Start the following cycle transmits normally.
6. Asynchronous reset mid-stream. Rst low between clock edges during SHIFT.
   - All outputs go to 0 immediately, before the next edge; CS=000.
   - After release, idle until Start.

Source files
------------

// File: rtl/seq_1010_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern MSB-first Reps times, first bit one cycle after Start.
// No backpressure; Start is ignored while busy, Abort cancels. SEQ_TX_OVERLAP_EN shortens later repetitions by OVL_LEN bits.
module seq_1010_pattern_tx #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 0,
    parameter int OVL_LEN = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic [PAT_W-1:0] Pattern,
    input  logic [CNT_W-1:0] Reps,
    output logic             Out,
    output logic             Out_Vld,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       CS,
    output logic [2:0]       NS
);

`ifdef SEQ_TX_OVERLAP_EN
    localparam bit OVL_EN = 1'b1;
`else
    localparam bit OVL_EN = 1'b0;
`endif

    localparam int IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int OVL_EFF = OVL_EN ? OVL_LEN : 0;
    localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_RELOAD = IDX_W'(PAT_W - OVL_EFF - 1);
    localparam logic [3:0]       GAP_LOAD   = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SHIFT = 3'b001,
        GAP   = 3'b010,
        DONE  = 3'b011
    } state_e;

    state_e             cs_q, ns_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [3:0]         gap_q, gap_d;
    logic               out_q, out_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;

    always_comb begin
        ns_d  = cs_q;
        pat_d = pat_q;
        idx_d = idx_q;
        rep_d = rep_q;
        gap_d = gap_q;
        if (cs_q != IDLE && Abort) begin
            ns_d = IDLE;
        end else begin
            case (cs_q)
                IDLE: begin
                    if (Start && !Abort) begin
                        ns_d  = SHIFT;
                        pat_d = Pattern;
                        idx_d = IDX_FULL;
                        // rep counts repetitions still to come after the current one
                        rep_d = (Reps == '0) ? '0 : Reps - 1'b1;
                    end
                end
                SHIFT: begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else if (rep_q == '0) begin
                        ns_d = DONE;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        if (GAP_CYC > 0) begin
                            ns_d  = GAP;
                            gap_d = GAP_LOAD;
                        end else begin
                            idx_d = IDX_RELOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        ns_d  = SHIFT;
                        idx_d = IDX_RELOAD;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                DONE:    ns_d = IDLE;
                default: ns_d = IDLE;
            endcase
        end

        // Outputs are precomputed from the next state so they land in flops
        out_d  = (ns_d == SHIFT) ? pat_d[idx_d] : 1'b0;
        vld_d  = (ns_d == SHIFT);
        done_d = (ns_d == DONE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cs_q   <= IDLE;
            pat_q  <= '0;
            idx_q  <= '0;
            rep_q  <= '0;
            gap_q  <= '0;
            out_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cs_q   <= ns_d;
            pat_q  <= pat_d;
            idx_q  <= idx_d;
            rep_q  <= rep_d;
            gap_q  <= gap_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    assign Out     = out_q;
    assign Out_Vld = vld_q;
    assign Done    = done_q;
    assign Busy    = (cs_q != IDLE);
    assign CS      = cs_q;
    assign NS      = ns_d;

endmodule
